// File: rtl/fetch_queue.sv
// Dual-issue fetch queue: buffers up to two {PC, IR} pairs per cycle in program
// order and presents the two oldest entries to decode/dispatch.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                     FQ_CLK,
  input  logic                     FQ_RST,
  input  logic                     FQ_FLUSH,
  input  logic                     FQ_IN_VALID0,
  input  logic                     FQ_IN_VALID1,
  input  logic [XLEN-1:0]          FQ_IN_PC0,
  input  logic [XLEN-1:0]          FQ_IN_PC1,
  input  logic [XLEN-1:0]          FQ_IN_IR0,
  input  logic [XLEN-1:0]          FQ_IN_IR1,
  output logic                     FQ_PC_LD,
  output logic                     FQ_OUT_VALID0,
  output logic                     FQ_OUT_VALID1,
  output logic [XLEN-1:0]          FQ_OUT_PC0,
  output logic [XLEN-1:0]          FQ_OUT_PC1,
  output logic [XLEN-1:0]          FQ_OUT_IR0,
  output logic [XLEN-1:0]          FQ_OUT_IR1,
  input  logic [1:0]               FQ_DEQ_CNT,
  output logic [$clog2(DEPTH):0]   FQ_COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [XLEN-1:0] ir_mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [AW-1:0]   head1;
  logic [AW-1:0]   tail1;
  logic [CW-1:0]   count;
  logic [1:0]      enq_n;
  logic [1:0]      deq_req;
  logic [1:0]      deq_n;

  // Handshake: a pair is taken on an edge where FQ_IN_VALID0 and FQ_PC_LD are both
  // high (slot 1 rides along when FQ_IN_VALID1 is also high); otherwise the fetch
  // side re-presents it. The consumer retires FQ_DEQ_CNT entries, clipped to the
  // valid ones, on every edge.
  assign head1 = head + AW'(1);
  assign tail1 = tail + AW'(1);

  assign FQ_PC_LD      = (count <= CW'(DEPTH - 2));
  assign FQ_OUT_VALID0 = (count >= CW'(1));
  assign FQ_OUT_VALID1 = (count >= CW'(2));
  assign FQ_OUT_PC0    = pc_mem[head];
  assign FQ_OUT_PC1    = pc_mem[head1];
  assign FQ_OUT_IR0    = ir_mem[head];
  assign FQ_OUT_IR1    = ir_mem[head1];
  assign FQ_COUNT      = count;

  always_comb begin
    enq_n = 2'd0;
    if (FQ_PC_LD && FQ_IN_VALID0) begin
      enq_n = FQ_IN_VALID1 ? 2'd2 : 2'd1;
    end
  end

  always_comb begin
    deq_req = (FQ_DEQ_CNT == 2'd3) ? 2'd2 : FQ_DEQ_CNT;
    deq_n   = deq_req;
    if (CW'(deq_req) > count) begin
      deq_n = count[1:0];
    end
  end

  always_ff @(posedge FQ_CLK or posedge FQ_RST) begin
    if (FQ_RST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i] <= '0;
        ir_mem[i] <= '0;
      end
    end else if (FQ_FLUSH) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_n != 2'd0) begin
        pc_mem[tail] <= FQ_IN_PC0;
        ir_mem[tail] <= FQ_IN_IR0;
      end
      // Slot 1 goes to tail+1, which wraps to entry 0 from the last entry.
      if (enq_n == 2'd2) begin
        pc_mem[tail1] <= FQ_IN_PC1;
        ir_mem[tail1] <= FQ_IN_IR1;
      end
      tail  <= tail + AW'(enq_n);
      head  <= head + AW'(deq_n);
      count <= count + CW'(enq_n) - CW'(deq_n);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/stall, streaming, partial pairs,
// wrap-around, flush and asynchronous mid-run reset.
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid0, in_valid1;
  logic [XLEN-1:0] in_pc0, in_pc1, in_ir0, in_ir1;
  logic            pc_ld;
  logic            out_valid0, out_valid1;
  logic [XLEN-1:0] out_pc0, out_pc1, out_ir0, out_ir1;
  logic [1:0]      deq_cnt;
  logic [3:0]      count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [XLEN-1:0] exp_q[$];

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .FQ_CLK(clk), .FQ_RST(rst), .FQ_FLUSH(flush),
    .FQ_IN_VALID0(in_valid0), .FQ_IN_VALID1(in_valid1),
    .FQ_IN_PC0(in_pc0), .FQ_IN_PC1(in_pc1),
    .FQ_IN_IR0(in_ir0), .FQ_IN_IR1(in_ir1),
    .FQ_PC_LD(pc_ld),
    .FQ_OUT_VALID0(out_valid0), .FQ_OUT_VALID1(out_valid1),
    .FQ_OUT_PC0(out_pc0), .FQ_OUT_PC1(out_pc1),
    .FQ_OUT_IR0(out_ir0), .FQ_OUT_IR1(out_ir1),
    .FQ_DEQ_CNT(deq_cnt), .FQ_COUNT(count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic drive(input logic v0, input logic v1, input logic [XLEN-1:0] pc0,
                       input logic [1:0] deq, input logic fl);
    in_valid0 = v0;
    in_valid1 = v1;
    in_pc0    = pc0;
    in_pc1    = pc0 + 32'h4;
    in_ir0    = pc0 ^ 32'hA5A5_0000;
    in_ir1    = (pc0 + 32'h4) ^ 32'hA5A5_0000;
    deq_cnt   = deq;
    flush     = fl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #12;
    total_cnt++;
    if (count !== 4'd0 || pc_ld !== 1'b1 || out_valid0 !== 1'b0 || out_valid1 !== 1'b0)
      $display("FAIL reset_ctrl: count=%0d pc_ld=%b v0=%b v1=%b want 0/1/0/0",
               count, pc_ld, out_valid0, out_valid1);
    else pass_cnt++;
    total_cnt++;
    if (out_pc0 !== 32'h0 || out_pc1 !== 32'h0 || out_ir0 !== 32'h0 || out_ir1 !== 32'h0)
      $display("FAIL reset_data: pc0=%h pc1=%h ir0=%h ir1=%h want all 0",
               out_pc0, out_pc1, out_ir0, out_ir1);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill_stall();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'(8 * i), 2'd0, 1'b0);
      total_cnt++;
      if (pc_ld !== 1'b1) $display("FAIL fill_pc_ld%0d: got %b want 1", i, pc_ld);
      else pass_cnt++;
      step();
    end
    idle();
    total_cnt++;
    if (count !== 4'd8 || pc_ld !== 1'b0)
      $display("FAIL fill_full: count=%0d pc_ld=%b want 8/0", count, pc_ld);
    else pass_cnt++;
    total_cnt++;
    if (out_pc0 !== 32'h00 || out_pc1 !== 32'h04 || out_ir1 !== 32'hA5A5_0004)
      $display("FAIL fill_head: pc0=%h pc1=%h ir1=%h want 0/4/a5a50004", out_pc0, out_pc1, out_ir1);
    else pass_cnt++;
    drive(1'b1, 1'b1, 32'h20, 2'd0, 1'b0);
    step();
    idle();
    total_cnt++;
    if (count !== 4'd8 || out_pc0 !== 32'h00)
      $display("FAIL fill_drop: count=%0d pc0=%h want 8/0", count, out_pc0);
    else pass_cnt++;
    drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
    step();
    idle();
    total_cnt++;
    if (count !== 4'd0 || pc_ld !== 1'b1)
      $display("FAIL fill_flush: count=%0d pc_ld=%b want 0/1", count, pc_ld);
    else pass_cnt++;
  endtask

  task automatic test_streaming();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 32'(8 * k), 2'd2, 1'b0);
      step();
      total_cnt++;
      if (count !== 4'd2 || out_pc0 !== 32'(8 * k) || out_pc1 !== 32'(8 * k + 4)
          || out_ir0 !== (32'(8 * k) ^ 32'hA5A5_0000))
        $display("FAIL stream%0d: count=%0d pc0=%h pc1=%h ir0=%h want 2/%h/%h",
                 k, count, out_pc0, out_pc1, out_ir0, 8 * k, 8 * k + 4);
      else pass_cnt++;
    end
    drive(1'b0, 1'b0, 32'h0, 2'd2, 1'b0);
    step();
    idle();
    total_cnt++;
    if (count !== 4'd0 || out_valid0 !== 1'b0)
      $display("FAIL stream_drain: count=%0d v0=%b want 0/0", count, out_valid0);
    else pass_cnt++;
  endtask

  task automatic test_partial();
    drive(1'b1, 1'b0, 32'h10, 2'd0, 1'b0);
    in_ir0 = 32'h0050_0093;
    step();
    idle();
    total_cnt++;
    if (count !== 4'd1 || out_valid0 !== 1'b1 || out_valid1 !== 1'b0
        || out_pc0 !== 32'h10 || out_ir0 !== 32'h0050_0093)
      $display("FAIL partial_enq: count=%0d v0=%b v1=%b pc0=%h ir0=%h want 1/1/0/10/00500093",
               count, out_valid0, out_valid1, out_pc0, out_ir0);
    else pass_cnt++;
    drive(1'b0, 1'b0, 32'h0, 2'd3, 1'b0);
    step();
    total_cnt++;
    if (count !== 4'd0 || out_valid0 !== 1'b0)
      $display("FAIL partial_overdeq: count=%0d v0=%b want 0/0", count, out_valid0);
    else pass_cnt++;
    step();
    idle();
    total_cnt++;
    if (count !== 4'd0 || pc_ld !== 1'b1)
      $display("FAIL empty_deq: count=%0d pc_ld=%b want 0/1", count, pc_ld);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [XLEN-1:0] e;
    drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
    step();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h200 + 32'(8 * i), 2'd0, 1'b0);
      exp_q.push_back(32'h200 + 32'(8 * i));
      exp_q.push_back(32'h204 + 32'(8 * i));
      step();
    end
    total_cnt++;
    if (count !== 4'd6 || pc_ld !== 1'b1)
      $display("FAIL wrap_six: count=%0d pc_ld=%b want 6/1", count, pc_ld);
    else pass_cnt++;
    drive(1'b1, 1'b0, 32'h218, 2'd0, 1'b0);
    exp_q.push_back(32'h218);
    step();
    total_cnt++;
    if (count !== 4'd7 || pc_ld !== 1'b0)
      $display("FAIL wrap_seven: count=%0d pc_ld=%b want 7/0", count, pc_ld);
    else pass_cnt++;
    // pair offered at count 7 alongside a dequeue must still be dropped
    drive(1'b1, 1'b1, 32'h400, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      idle();
      deq_cnt = 2'd2;
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
    end
    idle();
    total_cnt++;
    if (count !== 4'd1 || out_pc0 !== exp_q[0])
      $display("FAIL wrap_deq6: count=%0d pc0=%h want 1/%h", count, out_pc0, exp_q[0]);
    else pass_cnt++;
    drive(1'b1, 1'b1, 32'h100, 2'd0, 1'b0);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    step();
    idle();
    total_cnt++;
    if (count !== 4'd3 || out_pc0 !== 32'h218 || out_pc1 !== 32'h100)
      $display("FAIL wrap_enq: count=%0d pc0=%h pc1=%h want 3/218/100", count, out_pc0, out_pc1);
    else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (out_valid0 !== 1'b1 || out_pc0 !== e)
        $display("FAIL wrap_order: v0=%b pc0=%h want 1/%h", out_valid0, out_pc0, e);
      else pass_cnt++;
      deq_cnt = 2'd1;
      step();
      idle();
    end
    total_cnt++;
    if (count !== 4'd0)
      $display("FAIL wrap_empty: count=%0d want 0", count);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 32'h500 + 32'(8 * i), 2'd0, 1'b0);
      step();
    end
    drive(1'b1, 1'b0, 32'h510, 2'd0, 1'b0);
    step();
    idle();
    total_cnt++;
    if (count !== 4'd5)
      $display("FAIL flush_pre: count=%0d want 5", count);
    else pass_cnt++;
    drive(1'b1, 1'b1, 32'h600, 2'd1, 1'b1);
    step();
    idle();
    total_cnt++;
    if (count !== 4'd0 || out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || pc_ld !== 1'b1)
      $display("FAIL flush_clear: count=%0d v0=%b v1=%b pc_ld=%b want 0/0/0/1",
               count, out_valid0, out_valid1, pc_ld);
    else pass_cnt++;
    drive(1'b1, 1'b1, 32'h300, 2'd0, 1'b0);
    step();
    idle();
    total_cnt++;
    if (count !== 4'd2 || out_pc0 !== 32'h300 || out_pc1 !== 32'h304)
      $display("FAIL flush_next: count=%0d pc0=%h pc1=%h want 2/300/304", count, out_pc0, out_pc1);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (count !== 4'd0 || out_valid0 !== 1'b0 || pc_ld !== 1'b1 || out_pc0 !== 32'h0)
      $display("FAIL async_rst: count=%0d v0=%b pc_ld=%b pc0=%h want 0/0/1/0",
               count, out_valid0, pc_ld, out_pc0);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 32'h700, 2'd0, 1'b0);
    step();
    idle();
    total_cnt++;
    if (count !== 4'd2 || out_pc0 !== 32'h700 || out_pc1 !== 32'h704)
      $display("FAIL post_rst: count=%0d pc0=%h pc1=%h want 2/700/704", count, out_pc0, out_pc1);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    @(posedge clk);
    #1;
    test_fill_stall();
    test_streaming();
    test_partial();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
